// File: rtl/pippo_div_iter.sv
// Iterative non-restoring radix-2 divider: Z_WIDTH-bit dividend by D_WIDTH-bit divisor,
// signed or unsigned, one quotient bit per cycle, with divide-by-zero and overflow flags.
module pippo_div_iter #(
  parameter int Z_WIDTH = 64,
  parameter int D_WIDTH = Z_WIDTH / 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               sgn,
  input  logic [Z_WIDTH-1:0] z,
  input  logic [D_WIDTH-1:0] d,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] q,
  output logic [D_WIDTH-1:0] s,
  output logic               div0,
  output logic               ovf
);

  localparam int P_WIDTH = Z_WIDTH + 1;
  localparam logic [D_WIDTH-1:0] Q_NEG_MAX = {1'b1, {(D_WIDTH-1){1'b0}}};
  localparam logic [D_WIDTH-1:0] CNT_LOAD  = D_WIDTH'(D_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t state_q, state_d;

  logic [Z_WIDTH-1:0] z_r;
  logic [D_WIDTH-1:0] d_r;
  logic               sgn_r;
  logic [P_WIDTH-1:0] pr;
  logic [D_WIDTH-1:0] dmag_r;
  logic [D_WIDTH-1:0] q_acc;
  logic [D_WIDTH-1:0] s_acc;
  logic [D_WIDTH-1:0] cnt;
  logic               q_neg;
  logic               r_neg;

  logic               z_neg, d_neg;
  logic [Z_WIDTH-1:0] z_mag;
  logic [D_WIDTH-1:0] d_mag;
  logic               prep_div0, prep_ovf;
  logic [P_WIDTH-1:0] div_al;
  logic [P_WIDTH-1:0] pr_sh;
  logic [P_WIDTH-1:0] pr_nxt;
  logic [D_WIDTH-1:0] r_mag;
  logic               fix_ovf;

  assign z_neg  = sgn_r & z_r[Z_WIDTH-1];
  assign d_neg  = sgn_r & d_r[D_WIDTH-1];
  assign z_mag  = z_neg ? -z_r : z_r;
  assign d_mag  = d_neg ? -d_r : d_r;

  assign prep_div0 = (d_r == '0);
  assign prep_ovf  = (z_mag[Z_WIDTH-1:D_WIDTH] >= d_mag);

  // The shift may wrap the top bit, but every add/sub result fits the register, so the
  // modular sum is exact and only the post-add value is ever inspected.
  assign div_al = {1'b0, dmag_r, {D_WIDTH{1'b0}}};
  assign pr_sh  = {pr[P_WIDTH-2:0], 1'b0};
  assign pr_nxt = pr[P_WIDTH-1] ? (pr_sh + div_al) : (pr_sh - div_al);

  // Low half of pr is all zeros after the last shift, so correction only touches the top.
  assign r_mag  = pr[P_WIDTH-1] ? (pr[Z_WIDTH-1:D_WIDTH] + dmag_r) : pr[Z_WIDTH-1:D_WIDTH];

  assign fix_ovf = sgn_r & (q_neg ? (q_acc > Q_NEG_MAX) : q_acc[D_WIDTH-1]);

  // NOTE: every variable written in an always_comb gets a default first; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    unique case (state_q)
      IDLE: if (start) state_d = PREP;
      PREP: begin
        busy = 1'b1;
        if (prep_div0 || prep_ovf) state_d = DONE;
        else                       state_d = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_d = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_r    <= '0;
      d_r    <= '0;
      sgn_r  <= 1'b0;
      pr     <= '0;
      dmag_r <= '0;
      q_acc  <= '0;
      s_acc  <= '0;
      cnt    <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
      done   <= 1'b0;
      q      <= '0;
      s      <= '0;
      div0   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            z_r   <= z;
            d_r   <= d;
            sgn_r <= sgn;
            div0  <= 1'b0;
            ovf   <= 1'b0;
          end
        end
        PREP: begin
          pr     <= {1'b0, z_mag};
          dmag_r <= d_mag;
          q_neg  <= z_neg ^ d_neg;
          r_neg  <= z_neg;
          q_acc  <= '0;
          cnt    <= CNT_LOAD;
          if (prep_div0)     div0 <= 1'b1;
          else if (prep_ovf) ovf  <= 1'b1;
        end
        CALC: begin
          pr    <= pr_nxt;
          q_acc <= {q_acc[D_WIDTH-2:0], ~pr_nxt[P_WIDTH-1]};
          if (cnt != '0) cnt <= cnt - D_WIDTH'(1);
        end
        FIX: begin
          ovf   <= fix_ovf;
          q_acc <= q_neg ? -q_acc : q_acc;
          s_acc <= r_neg ? -r_mag : r_mag;
        end
        DONE: begin
          done <= 1'b1;
          q    <= (div0 || ovf) ? '0 : q_acc;
          s    <= (div0 || ovf) ? '0 : s_acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pippo_div_iter.sv
// Self-checking bench for pippo_div_iter (Z_WIDTH=64): directed vectors, handshake and
// reset sequences, and random operations checked against an arithmetic reference model.
module tb_pippo_div_iter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        sgn;
  logic [63:0] z;
  logic [31:0] d;
  logic        busy, done, div0, ovf;
  logic [31:0] q, s;

  int checks   = 0;
  int failures = 0;

  pippo_div_iter #(.Z_WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sgn(sgn), .z(z), .d(d),
    .busy(busy), .done(done), .q(q), .s(s), .div0(div0), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [63:0] zz;
    logic [31:0] dd;
    logic [31:0] eq;
    logic [31:0] es;
    logic        e0;
    logic        eo;
    int          el;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer division, flags from the magnitude and range rules.
  function automatic void model(input logic sg, input logic [63:0] zz, input logic [31:0] dd,
                                output logic [31:0] eq, output logic [31:0] es,
                                output logic e0, output logic eo, output int el);
    logic [63:0] zm;
    logic [31:0] dm;
    longint      zs, ds, qq, rr;
    eq = '0; es = '0; e0 = 1'b0; eo = 1'b0;
    zm = (sg && zz[63]) ? -zz : zz;
    dm = (sg && dd[31]) ? -dd : dd;
    if (dd == 0) begin
      e0 = 1'b1; el = 2;
    end else if ((zm >> 32) >= {32'd0, dm}) begin
      eo = 1'b1; el = 2;
    end else begin
      el = 35;
      if (!sg) begin
        eq = 32'(zz / {32'd0, dd});
        es = 32'(zz % {32'd0, dd});
      end else begin
        zs = $signed(zz);
        ds = longint'($signed(dd));
        qq = zs / ds;
        rr = zs % ds;
        if (qq > 64'sd2147483647 || qq < -64'sd2147483648) eo = 1'b1;
        else begin
          eq = qq[31:0];
          es = rr[31:0];
        end
      end
    end
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge where done is seen.
  task automatic run_op(input logic sg, input logic [63:0] zz, input logic [31:0] dd,
                        input bit poke, output int lat);
    sgn = sg; z = zz; d = dd; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0; z = ~zz; d = ~dd;
    @(negedge clk);
    check("busy_after_accept", 64'(busy), 64'd1);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk);
      lat++;
      #1;
      if (poke && (lat == 4 || lat == 20)) begin
        start = 1'b1; z = 64'd999; d = 32'd3; sgn = 1'b0;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_checked(input string tag, input logic sg, input logic [63:0] zz,
                             input logic [31:0] dd, input bit poke);
    logic [31:0] eq, es;
    logic        e0, eo;
    int          el, lat;
    model(sg, zz, dd, eq, es, e0, eo, el);
    run_op(sg, zz, dd, poke, lat);
    check({tag, "_lat"},  64'(lat),  64'(el));
    check({tag, "_q"},    64'(q),    64'(eq));
    check({tag, "_s"},    64'(s),    64'(es));
    check({tag, "_div0"}, 64'(div0), 64'(e0));
    check({tag, "_ovf"},  64'(ovf),  64'(eo));
  endtask

  initial begin
    int          lat, n;
    logic        sg;
    logic [31:0] dmag, dd, zhi;
    logic [63:0] zz;
    int          mode;

    vecs[0]  = '{1'b0, 64'd100,                  32'd7,          32'd14,         32'd2,          1'b0, 1'b0, 35};
    vecs[1]  = '{1'b1, 64'hFFFFFFFF_FFFFFF9C,    32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 1'b0, 35};
    vecs[2]  = '{1'b1, 64'd100,                  32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 1'b0, 35};
    vecs[3]  = '{1'b0, 64'd12345,                32'd0,          32'd0,          32'd0,          1'b1, 1'b0, 2};
    vecs[4]  = '{1'b1, 64'hFFFFFFFF_FFFFFFFF,    32'd0,          32'd0,          32'd0,          1'b1, 1'b0, 2};
    vecs[5]  = '{1'b0, 64'h00000001_00000000,    32'd1,          32'd0,          32'd0,          1'b0, 1'b1, 2};
    vecs[6]  = '{1'b1, 64'hFFFFFFFF_80000000,    32'hFFFFFFFF,   32'd0,          32'd0,          1'b0, 1'b1, 35};
    vecs[7]  = '{1'b0, 64'hFFFFFFFE_FFFFFFFF,    32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   1'b0, 1'b0, 35};
    vecs[8]  = '{1'b1, 64'hFFFFFFFF_80000000,    32'd1,          32'h80000000,   32'd0,          1'b0, 1'b0, 35};
    vecs[9]  = '{1'b1, 64'h00000000_80000000,    32'd1,          32'd0,          32'd0,          1'b0, 1'b1, 35};
    vecs[10] = '{1'b0, 64'd0,                    32'd5,          32'd0,          32'd0,          1'b0, 1'b0, 35};

    rst_n = 1'b0; start = 1'b0; sgn = 1'b0; z = '0; d = '0;
    #23;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_q",    64'(q),    64'd0);
    check("reset_s",    64'(s),    64'd0);
    check("reset_flags", {62'd0, div0, ovf}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].sg, vecs[i].zz, vecs[i].dd, 1'b0, lat);
      check($sformatf("vec%0d_lat", i),  64'(lat),  64'(vecs[i].el));
      check($sformatf("vec%0d_q", i),    64'(q),    64'(vecs[i].eq));
      check($sformatf("vec%0d_s", i),    64'(s),    64'(vecs[i].es));
      check($sformatf("vec%0d_div0", i), 64'(div0), 64'(vecs[i].e0));
      check($sformatf("vec%0d_ovf", i),  64'(ovf),  64'(vecs[i].eo));
    end

    // start held high: a new op every 36 cycles, done a single-cycle pulse
    sgn = 1'b0; z = 64'd100; d = 32'd7; start = 1'b1;
    n = 0;
    for (int i = 0; i < 72; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done) n++;
    end
    start = 1'b0;
    check("held_start_done_count", 64'(n), 64'd2);
    check("held_start_q", 64'(q), 64'd14);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) n++;
    end
    check("idle_after_release", 64'(n), 64'd0);

    // start pulses while busy must be ignored
    run_checked("poke", 1'b0, 64'd100, 32'd7, 1'b1);

    // asynchronous reset in the middle of CALC
    sgn = 1'b0; z = 64'd1000; d = 32'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_done", 64'(done), 64'd0);
    check("midreset_q",    64'(q),    64'd0);
    check("midreset_s",    64'(s),    64'd0);
    check("midreset_flags", {62'd0, div0, ovf}, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) n++;
    end
    check("no_done_after_reset", 64'(n), 64'd0);
    run_checked("post_reset", 1'b0, 64'd100, 32'd7, 1'b0);

    for (int i = 0; i < 80; i++) begin
      sg   = 1'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 7));
      if (mode == 0)      dmag = 32'd0;
      else if (mode == 1) dmag = 32'($urandom_range(1, 15));
      else begin
        dmag = $urandom;
        if (sg) dmag[31] = 1'b0;
        if (dmag == 0) dmag = 32'd1;
      end
      if (mode == 7 || dmag == 0) zz = {$urandom, $urandom};
      else begin
        zhi = $urandom % dmag;
        zz  = {zhi, 32'($urandom)};
        if (sg && $urandom_range(0, 1) == 1) zz = -zz;
      end
      dd = dmag;
      if (sg && $urandom_range(0, 1) == 1) dd = -dmag;
      run_checked($sformatf("rand%0d", i), sg, zz, dd, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
